vga_menu_ctrl: RTL and testbench

Parametrised successor to the screen/menu FSM inside the VGA top level. Decodes four player buttons and drives the screen selector for the pixel pipeline. Manages N save/load slots with a cursor, and runs a req/ack handshake with the slot-storage block, with an ack timeout. Screen changes commit only at frame start (falling vs_n), so a frame never tears.

---
 rtl/vga_menu_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_vga_menu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_menu_ctrl.sv
// vga_menu_ctrl: button-driven screen/menu FSM with NUM_SLOTS save/load slots and a req/ack
// storage handshake with timeout. Define SLOT_WRAP_EN to make the slot cursor wrap at its ends.
module vga_menu_ctrl #(
    parameter int DATA_W      = 32,
    parameter int NUM_SLOTS   = 3,
    parameter int SLOT_W      = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vs_n,
    input  logic [3:0]        btn,
    input  logic [DATA_W-1:0] sensor_in,
    input  logic              save_ack,
    input  logic              load_ack,
    input  logic [DATA_W-1:0] load_data,
    output logic [1:0]        screen_sel,
    output logic [SLOT_W-1:0] cursor,
    output logic              save_req,
    output logic [SLOT_W-1:0] save_slot,
    output logic [DATA_W-1:0] save_data,
    output logic              load_req,
    output logic [SLOT_W-1:0] load_slot,
    output logic [DATA_W-1:0] game_data,
    output logic              game_valid,
    output logic              ack_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] SLOT_NONE  = '0;

    localparam logic [1:0] SCR_SPLASH = 2'd0;
    localparam logic [1:0] SCR_MAIN   = 2'd1;
    localparam logic [1:0] SCR_SL     = 2'd2;
    localparam logic [1:0] SCR_GAME   = 2'd3;

    typedef enum logic [2:0] {
        ST_SPLASH,
        ST_MAIN,
        ST_GAME,
        ST_SAVE_SEL,
        ST_SAVE_WAIT,
        ST_LOAD_SEL,
        ST_LOAD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SLOT_W-1:0] cur_q, cur_d;
    logic              save_req_q, save_req_d;
    logic [SLOT_W-1:0] save_slot_q, save_slot_d;
    logic [DATA_W-1:0] save_data_q, save_data_d;
    logic              load_req_q, load_req_d;
    logic [SLOT_W-1:0] load_slot_q, load_slot_d;
    logic [DATA_W-1:0] game_data_q, game_data_d;
    logic              game_valid_q, game_valid_d;
    logic              ack_err_q, ack_err_d;
    logic [1:0]        screen_q, screen_d;
    logic [SLOT_W-1:0] cur_out_q, cur_out_d;
    logic [3:0]        btn_s1_q, btn_s1_d;
    logic [3:0]        btn_s2_q, btn_s2_d;
    logic [3:0]        btn_prev_q, btn_prev_d;
    logic [3:0]        rise_q, rise_d;
    logic              vs_prev_q, vs_prev_d;

    logic              act_back, act_play, act_prev, act_next;
    logic              vs_fall;
    logic [SLOT_W-1:0] cur_dec, cur_inc;

    // The registered rise adds the third cycle of button latency.
    always_comb begin
        btn_s1_d   = btn;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        rise_d     = btn_s2_q & ~btn_prev_q;
        vs_prev_d  = vs_n;
        vs_fall    = vs_prev_q & ~vs_n;
        act_back   = rise_q[0];
        act_play   = rise_q[3] & ~rise_q[0];
        act_prev   = rise_q[1] & ~rise_q[0] & ~rise_q[3];
        act_next   = rise_q[2] & ~rise_q[0] & ~rise_q[3] & ~rise_q[1];
    end

    always_comb begin
        cur_dec = cur_q - SLOT_FIRST;
        cur_inc = cur_q + SLOT_FIRST;
        if (cur_q <= SLOT_FIRST) begin
`ifdef SLOT_WRAP_EN
            cur_dec = SLOT_LAST;
`else
            cur_dec = SLOT_FIRST;
`endif
        end
        if (cur_q >= SLOT_LAST) begin
`ifdef SLOT_WRAP_EN
            cur_inc = SLOT_FIRST;
`else
            cur_inc = SLOT_LAST;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        save_req_d   = save_req_q;
        save_slot_d  = save_slot_q;
        save_data_d  = save_data_q;
        load_req_d   = load_req_q;
        load_slot_d  = load_slot_q;
        game_data_d  = game_data_q;
        game_valid_d = game_valid_q;
        ack_err_d    = 1'b0;

        case (state_q)
            ST_SPLASH: begin
                if (|rise_q) state_d = ST_MAIN;
            end
            ST_MAIN: begin
                if (act_play) begin
                    state_d = ST_GAME;
                end else if (act_prev) begin
                    state_d = ST_SAVE_SEL;
                    cur_d   = SLOT_FIRST;
                end else if (act_next) begin
                    state_d = ST_LOAD_SEL;
                    cur_d   = SLOT_FIRST;
                end
            end
            ST_GAME: begin
                if (act_back) state_d = ST_MAIN;
            end
            ST_SAVE_SEL, ST_LOAD_SEL: begin
                if (act_back) begin
                    state_d = ST_MAIN;
                end else if (act_prev) begin
                    cur_d = cur_dec;
                end else if (act_next) begin
                    cur_d = cur_inc;
                end else if (act_play) begin
                    cnt_d = '0;
                    if (state_q == ST_SAVE_SEL) begin
                        save_data_d = sensor_in;
                        save_slot_d = cur_q;
                        save_req_d  = 1'b1;
                        state_d     = ST_SAVE_WAIT;
                    end else begin
                        load_slot_d = cur_q;
                        load_req_d  = 1'b1;
                        state_d     = ST_LOAD_WAIT;
                    end
                end
            end
            ST_SAVE_WAIT: begin
                if (save_ack || cnt_q == CNT_LAST) begin
                    save_req_d  = 1'b0;
                    save_slot_d = SLOT_NONE;
                    ack_err_d   = ~save_ack;
                    state_d     = ST_SAVE_SEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD_WAIT: begin
                if (load_ack) begin
                    game_data_d  = load_data;
                    game_valid_d = 1'b1;
                    load_req_d   = 1'b0;
                    load_slot_d  = SLOT_NONE;
                    state_d      = ST_GAME;
                end else if (cnt_q == CNT_LAST) begin
                    load_req_d  = 1'b0;
                    load_slot_d = SLOT_NONE;
                    ack_err_d   = 1'b1;
                    state_d     = ST_LOAD_SEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SPLASH;
        endcase
    end

    // Screen and cursor only change at frame start so a frame never tears.
    always_comb begin
        screen_d  = screen_q;
        cur_out_d = cur_out_q;
        if (vs_fall) begin
            case (state_q)
                ST_SPLASH: screen_d = SCR_SPLASH;
                ST_MAIN:   screen_d = SCR_MAIN;
                ST_GAME:   screen_d = SCR_GAME;
                default:   screen_d = SCR_SL;
            endcase
            case (state_q)
                ST_SAVE_SEL, ST_SAVE_WAIT, ST_LOAD_SEL, ST_LOAD_WAIT: cur_out_d = cur_q;
                default: cur_out_d = SLOT_NONE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SPLASH;
            cnt_q        <= '0;
            cur_q        <= SLOT_NONE;
            save_req_q   <= 1'b0;
            save_slot_q  <= SLOT_NONE;
            save_data_q  <= '0;
            load_req_q   <= 1'b0;
            load_slot_q  <= SLOT_NONE;
            game_data_q  <= '0;
            game_valid_q <= 1'b0;
            ack_err_q    <= 1'b0;
            screen_q     <= SCR_SPLASH;
            cur_out_q    <= SLOT_NONE;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_prev_q   <= '0;
            rise_q       <= '0;
            vs_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            save_req_q   <= save_req_d;
            save_slot_q  <= save_slot_d;
            save_data_q  <= save_data_d;
            load_req_q   <= load_req_d;
            load_slot_q  <= load_slot_d;
            game_data_q  <= game_data_d;
            game_valid_q <= game_valid_d;
            ack_err_q    <= ack_err_d;
            screen_q     <= screen_d;
            cur_out_q    <= cur_out_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_prev_q   <= btn_prev_d;
            rise_q       <= rise_d;
            vs_prev_q    <= vs_prev_d;
        end
    end

    assign screen_sel = screen_q;
    assign cursor     = cur_out_q;
    assign save_req   = save_req_q;
    assign save_slot  = save_slot_q;
    assign save_data  = save_data_q;
    assign load_req   = load_req_q;
    assign load_slot  = load_slot_q;
    assign game_data  = game_data_q;
    assign game_valid = game_valid_q;
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_vga_menu_ctrl.sv
// tb_vga_menu_ctrl: table-driven menu navigation with a scoreboard queue, plus hand-written
// sequences for latency, save/load handshakes, ack timeout and reset mid-handshake.
`timescale 1ns/1ps
module tb_vga_menu_ctrl;

    localparam int DATA_W      = 32;
    localparam int NUM_SLOTS   = 3;
    localparam int SLOT_W      = 4;
    localparam int ACK_TIMEOUT = 16;

`ifdef SLOT_WRAP_EN
    localparam logic [SLOT_W-1:0] PREV_AT_FIRST = SLOT_W'(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] NEXT_AT_LAST  = SLOT_W'(1);
`else
    localparam logic [SLOT_W-1:0] PREV_AT_FIRST = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] NEXT_AT_LAST  = SLOT_W'(NUM_SLOTS);
`endif

    logic              vga_clk = 1'b0;
    logic              reset;
    logic              vs_n;
    logic [3:0]        btn;
    logic [DATA_W-1:0] sensor_in;
    logic              save_ack;
    logic              load_ack;
    logic [DATA_W-1:0] load_data;
    logic [1:0]        screen_sel;
    logic [SLOT_W-1:0] cursor;
    logic              save_req;
    logic [SLOT_W-1:0] save_slot;
    logic [DATA_W-1:0] save_data;
    logic              load_req;
    logic [SLOT_W-1:0] load_slot;
    logic [DATA_W-1:0] game_data;
    logic              game_valid;
    logic              ack_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]        btn_mask;
        logic              pre_ack;
        logic [1:0]        exp_screen;
        logic [SLOT_W-1:0] exp_cursor;
        logic              exp_save_req;
        logic              exp_load_req;
    } vector_t;

    vector_t vectors[20];
    vector_t exp_queue[$];

    vga_menu_ctrl #(
        .DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .vs_n(vs_n), .btn(btn), .sensor_in(sensor_in),
        .save_ack(save_ack), .load_ack(load_ack), .load_data(load_data),
        .screen_sel(screen_sel), .cursor(cursor), .save_req(save_req), .save_slot(save_slot),
        .save_data(save_data), .load_req(load_req), .load_slot(load_slot),
        .game_data(game_data), .game_valid(game_valid), .ack_err(ack_err)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Returns on the falling edge right after the edge where the press takes effect.
    task automatic pressButton(input logic [3:0] mask);
        @(negedge vga_clk) btn = mask;
        @(negedge vga_clk);
        @(negedge vga_clk) btn = 4'b0000;
        @(negedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic frameStart();
        @(negedge vga_clk) vs_n = 1'b0;
        @(negedge vga_clk) vs_n = 1'b1;
        @(negedge vga_clk);
    endtask

    task automatic applyStimulus(input int idx);
        if (vectors[idx].pre_ack) begin
            @(negedge vga_clk) save_ack = 1'b1;
            @(negedge vga_clk) save_ack = 1'b0;
        end
        exp_queue.push_back(vectors[idx]);
        pressButton(vectors[idx].btn_mask);
        frameStart();
    endtask

    task automatic checkOutput(input int idx);
        vector_t exp_v;
        if (exp_queue.size() == 0) begin
            checkVal($sformatf("vec%0d scoreboard empty", idx), 64'd0, 64'd1);
        end else begin
            exp_v = exp_queue.pop_front();
            checkVal($sformatf("vec%0d screen_sel", idx), 64'(screen_sel), 64'(exp_v.exp_screen));
            checkVal($sformatf("vec%0d cursor", idx), 64'(cursor), 64'(exp_v.exp_cursor));
            checkVal($sformatf("vec%0d save_req", idx), 64'(save_req), 64'(exp_v.exp_save_req));
            checkVal($sformatf("vec%0d load_req", idx), 64'(load_req), 64'(exp_v.exp_load_req));
        end
    endtask

    // Starts on the falling edge after WAIT entry; optionally acks on the final WAIT cycle.
    task automatic runTimeout(input logic with_ack);
        for (int j = 0; j < ACK_TIMEOUT; j++) begin
            if (with_ack && j == ACK_TIMEOUT - 1) save_ack = 1'b1;
            checkVal($sformatf("wait cycle %0d save_req", j), 64'(save_req), 64'd1);
            checkVal($sformatf("wait cycle %0d ack_err", j), 64'(ack_err), 64'd0);
            @(negedge vga_clk);
        end
        save_ack = 1'b0;
        checkVal("timeout save_req dropped", 64'(save_req), 64'd0);
        checkVal("timeout save_slot cleared", 64'(save_slot), 64'd0);
        checkVal("timeout ack_err", 64'(ack_err), with_ack ? 64'd0 : 64'd1);
        @(negedge vga_clk);
        checkVal("timeout ack_err one cycle", 64'(ack_err), 64'd0);
    endtask

    initial begin
        vectors[0]  = '{4'b0010, 1'b0, 2'd2, SLOT_W'(1), 1'b0, 1'b0};
        vectors[1]  = '{4'b0100, 1'b0, 2'd2, SLOT_W'(2), 1'b0, 1'b0};
        vectors[2]  = '{4'b0100, 1'b0, 2'd2, SLOT_W'(3), 1'b0, 1'b0};
        vectors[3]  = '{4'b0010, 1'b0, 2'd2, SLOT_W'(2), 1'b0, 1'b0};
        vectors[4]  = '{4'b0001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[5]  = '{4'b0100, 1'b0, 2'd2, SLOT_W'(1), 1'b0, 1'b0};
        vectors[6]  = '{4'b0100, 1'b0, 2'd2, SLOT_W'(2), 1'b0, 1'b0};
        vectors[7]  = '{4'b0010, 1'b0, 2'd2, SLOT_W'(1), 1'b0, 1'b0};
        vectors[8]  = '{4'b0010, 1'b0, 2'd2, PREV_AT_FIRST, 1'b0, 1'b0};
        vectors[9]  = '{4'b0001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[10] = '{4'b0001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[11] = '{4'b1000, 1'b0, 2'd3, SLOT_W'(0), 1'b0, 1'b0};
        vectors[12] = '{4'b0010, 1'b0, 2'd3, SLOT_W'(0), 1'b0, 1'b0};
        vectors[13] = '{4'b0001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[14] = '{4'b1001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[15] = '{4'b0110, 1'b0, 2'd2, SLOT_W'(1), 1'b0, 1'b0};
        vectors[16] = '{4'b1000, 1'b0, 2'd2, SLOT_W'(1), 1'b1, 1'b0};
        vectors[17] = '{4'b1001, 1'b1, 2'd1, SLOT_W'(0), 1'b0, 1'b0};
        vectors[18] = '{4'b1100, 1'b0, 2'd3, SLOT_W'(0), 1'b0, 1'b0};
        vectors[19] = '{4'b0001, 1'b0, 2'd1, SLOT_W'(0), 1'b0, 1'b0};

        reset = 1'b1; vs_n = 1'b1; btn = 4'b0; sensor_in = '0;
        save_ack = 1'b0; load_ack = 1'b0; load_data = '0;
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        checkVal("reset screen_sel", 64'(screen_sel), 64'd0);
        checkVal("reset cursor", 64'(cursor), 64'd0);
        checkVal("reset save_req", 64'(save_req), 64'd0);
        checkVal("reset load_req", 64'(load_req), 64'd0);
        checkVal("reset save_slot", 64'(save_slot), 64'd0);
        checkVal("reset load_slot", 64'(load_slot), 64'd0);
        checkVal("reset save_data", 64'(save_data), 64'd0);
        checkVal("reset game_data", 64'(game_data), 64'd0);
        checkVal("reset game_valid", 64'(game_valid), 64'd0);
        checkVal("reset ack_err", 64'(ack_err), 64'd0);

        // Frame start on the same edge the press lands must still commit SPLASH.
        @(negedge vga_clk) btn = 4'b1000;
        @(negedge vga_clk);
        @(negedge vga_clk) btn = 4'b0000;
        @(negedge vga_clk) vs_n = 1'b0;
        @(negedge vga_clk) vs_n = 1'b1;
        checkVal("latency edge+3 commit screen_sel", 64'(screen_sel), 64'd0);
        repeat (4) @(negedge vga_clk);
        checkVal("no frame no commit screen_sel", 64'(screen_sel), 64'd0);
        frameStart();
        checkVal("splash->main screen_sel", 64'(screen_sel), 64'd1);

        // Frame start one edge after the press lands sees the new state.
        @(negedge vga_clk) btn = 4'b1000;
        @(negedge vga_clk);
        @(negedge vga_clk) btn = 4'b0000;
        @(negedge vga_clk);
        @(negedge vga_clk) vs_n = 1'b0;
        @(negedge vga_clk) vs_n = 1'b1;
        checkVal("latency edge+4 commit screen_sel", 64'(screen_sel), 64'd3);
        pressButton(4'b0001);
        checkVal("game->main before frame screen_sel", 64'(screen_sel), 64'd3);
        frameStart();
        checkVal("game->main screen_sel", 64'(screen_sel), 64'd1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(i);
            checkOutput(i);
        end

        // Save handshake into slot 3 with a late ack.
        pressButton(4'b0010);
        pressButton(4'b0100);
        pressButton(4'b0100);
        sensor_in = 32'hA5A5_0F0F;
        pressButton(4'b1000);
        sensor_in = 32'h1111_2222;
        checkVal("save save_req", 64'(save_req), 64'd1);
        checkVal("save save_slot", 64'(save_slot), 64'd3);
        checkVal("save save_data", 64'(save_data), 64'hA5A5_0F0F);
        repeat (5) @(negedge vga_clk);
        checkVal("save wait save_req held", 64'(save_req), 64'd1);
        checkVal("save wait save_data stable", 64'(save_data), 64'hA5A5_0F0F);
        save_ack = 1'b1;
        @(negedge vga_clk) save_ack = 1'b0;
        checkVal("save ack save_req", 64'(save_req), 64'd0);
        checkVal("save ack save_slot", 64'(save_slot), 64'd0);
        checkVal("save ack ack_err", 64'(ack_err), 64'd0);
        frameStart();
        checkVal("save return screen_sel", 64'(screen_sel), 64'd2);
        checkVal("save return cursor", 64'(cursor), 64'd3);
        pressButton(4'b0100);
        frameStart();
        checkVal("next at last cursor", 64'(cursor), 64'(NEXT_AT_LAST));
        pressButton(4'b0001);

        // Ack timeout without ack, then with ack on the final WAIT cycle.
        pressButton(4'b0010);
        pressButton(4'b1000);
        runTimeout(1'b0);
        frameStart();
        checkVal("timeout return screen_sel", 64'(screen_sel), 64'd2);
        checkVal("timeout return cursor", 64'(cursor), 64'd1);
        pressButton(4'b1000);
        runTimeout(1'b1);
        frameStart();
        checkVal("late ack return screen_sel", 64'(screen_sel), 64'd2);
        pressButton(4'b0001);

        // Acks outside a WAIT state must be ignored.
        @(negedge vga_clk) begin
            save_ack = 1'b1; load_ack = 1'b1; load_data = 32'hFFFF_FFFF;
        end
        @(negedge vga_clk) begin
            save_ack = 1'b0; load_ack = 1'b0; load_data = '0;
        end
        @(negedge vga_clk);
        checkVal("stray ack game_valid", 64'(game_valid), 64'd0);
        checkVal("stray ack game_data", 64'(game_data), 64'd0);
        checkVal("stray ack ack_err", 64'(ack_err), 64'd0);

        // Load handshake from slot 1.
        pressButton(4'b0100);
        pressButton(4'b1000);
        checkVal("load load_req", 64'(load_req), 64'd1);
        checkVal("load load_slot", 64'(load_slot), 64'd1);
        checkVal("load save_req", 64'(save_req), 64'd0);
        repeat (3) @(negedge vga_clk);
        load_ack = 1'b1; load_data = 32'h0000_1234;
        @(negedge vga_clk) begin
            load_ack = 1'b0; load_data = '0;
        end
        checkVal("load game_data", 64'(game_data), 64'h0000_1234);
        checkVal("load game_valid", 64'(game_valid), 64'd1);
        checkVal("load load_req dropped", 64'(load_req), 64'd0);
        checkVal("load load_slot cleared", 64'(load_slot), 64'd0);
        frameStart();
        checkVal("load screen_sel", 64'(screen_sel), 64'd3);
        checkVal("load cursor", 64'(cursor), 64'd0);

        // Reset while a load request is outstanding.
        pressButton(4'b0001);
        pressButton(4'b0100);
        pressButton(4'b1000);
        checkVal("pre-reset load_req", 64'(load_req), 64'd1);
        reset = 1'b1;
        #1;
        checkVal("async reset load_req", 64'(load_req), 64'd0);
        checkVal("async reset load_slot", 64'(load_slot), 64'd0);
        checkVal("async reset screen_sel", 64'(screen_sel), 64'd0);
        checkVal("async reset game_valid", 64'(game_valid), 64'd0);
        checkVal("async reset game_data", 64'(game_data), 64'd0);
        @(negedge vga_clk) reset = 1'b0;
        @(negedge vga_clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
